cohort_config_slave: RTL and testbench

// - Responder end of the uncached config interface in the cohort tile.
// - Decodes master writes/reads into a small register file: ADDR, OP, SIZE, START, STATUS, DONE_CNT.
// - Launches one transaction to the cohort engine through a valid/ready request port.
// - Tracks engine completion and returns registered read data.

---
 rtl/cohort_config_slave_pkg.sv | 34 +++
 rtl/cohort_config_slave_if.sv | 29 ++
 rtl/cohort_config_slave_watchdog.sv | 29 ++
 rtl/cohort_config_slave.sv | 151 +++++++++++++++
 tb/tb_cohort_config_slave.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cohort_config_slave_pkg.sv
// Shared types, register offsets, STATUS bit indices and FSM encodings for the
// cohort config responder.
package cohort_config_slave_pkg;
  localparam int unsigned PADDR_W = 40;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned OFF_W   = 12;

  typedef logic [PADDR_W-1:0] paddr_t;
  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [SIZE_W-1:0]  size_t;
  typedef logic [OP_W-1:0]    req_type_t;
  typedef logic [OFF_W-1:0]   cfg_off_t;

  typedef enum logic {CFG_LOAD = 1'b0, CFG_STORE = 1'b1} transaction_t;

  localparam cfg_off_t CFG_ADDR_OFF  = 12'h000;
  localparam cfg_off_t CFG_OP_OFF    = 12'h004;
  localparam cfg_off_t CFG_SIZE_OFF  = 12'h008;
  localparam cfg_off_t CFG_START_OFF = 12'h00C;
  localparam cfg_off_t CFG_STAT_OFF  = 12'h010;
  localparam cfg_off_t CFG_DCNT_OFF  = 12'h014;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_ERR  = 2;
  localparam int unsigned ST_TMO  = 3;

  typedef logic [1:0] cfg_state_e;
  localparam cfg_state_e IDLE = 2'd0;
  localparam cfg_state_e REQ  = 2'd1;
  localparam cfg_state_e BUSY = 2'd2;
endpackage

// File: rtl/cohort_config_slave_if.sv
// Config bus plus engine request/completion signals of the cohort tile.
interface cohort_config_slave_if;
  import cohort_config_slave_pkg::*;

  logic         cfg_valid;
  paddr_t       cfg_addr;
  data_t        cfg_data;
  size_t        cfg_size;
  transaction_t cfg_type;
  data_t        cfg_read_data;
  logic         cfg_read_valid;
  logic         req_valid;
  logic         req_ready;
  paddr_t       req_addr;
  req_type_t    req_op;
  size_t        req_size;
  logic         done_valid;
  logic         done_err;

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_size, cfg_type, req_ready, done_valid, done_err,
    output cfg_read_data, cfg_read_valid, req_valid, req_addr, req_op, req_size
  );

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_size, cfg_type, req_ready, done_valid, done_err,
    input  cfg_read_data, cfg_read_valid, req_valid, req_addr, req_op, req_size
  );
endinterface

// File: rtl/cohort_config_slave_watchdog.sv
// cohort_cfg_watchdog: counts active cycles and pulses expire_o on the LIMIT-th.
// Only compiled when COHORT_CFG_TIMEOUT_EN is defined.
`ifdef COHORT_CFG_TIMEOUT_EN
module cohort_cfg_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  output logic expire_o
);
  localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = active_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (active_i && !expire_o) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule
`endif

// File: rtl/cohort_config_slave.sv
// Cohort config responder: register file, single-launch request FSM, completion
// tracking. Optional watchdog enabled by COHORT_CFG_TIMEOUT_EN.
module cohort_config_slave
  import cohort_config_slave_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cohort_config_slave_if.slave bus
);
  cfg_state_e  state_q, state_d;
  paddr_t      addr_q, addr_d;
  req_type_t   op_q, op_d;
  size_t       size_q, size_d;
  logic        done_q, done_d, err_q, err_d, tmo_q, tmo_d;
  logic [31:0] dcnt_q, dcnt_d;
  data_t       rdata_q, rdata_d;
  logic        rvalid_q;
  logic        wd_expire;

  cfg_off_t    off;
  logic        wr, rd, prot_wr, completing;
  logic [3:0]  status;
  logic        unused_bits;

  assign off        = bus.cfg_addr[OFF_W-1:0];
  assign wr         = bus.cfg_valid && (bus.cfg_type == CFG_STORE);
  assign rd         = bus.cfg_valid && (bus.cfg_type == CFG_LOAD);
  assign prot_wr    = wr && (off == CFG_ADDR_OFF || off == CFG_OP_OFF ||
                             off == CFG_SIZE_OFF || off == CFG_START_OFF);
  assign completing = (state_q == BUSY) && bus.done_valid;
  assign status     = {tmo_q, err_q, done_q, state_q != IDLE};

  assign unused_bits = ^{bus.cfg_size, bus.cfg_addr[PADDR_W-1:OFF_W],
                         bus.cfg_data[DATA_W-1:PADDR_W], TIMEOUT_CYCLES == 0};

`ifdef COHORT_CFG_TIMEOUT_EN
  cohort_cfg_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .active_i (state_q != IDLE),
    .expire_o (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  // W1C clears are applied first so that hardware sets later in the block win.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    size_d  = size_q;
    done_d  = done_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    dcnt_d  = dcnt_q;

    if (wr && off == CFG_STAT_OFF) begin
      if (bus.cfg_data[ST_DONE]) done_d = 1'b0;
      if (bus.cfg_data[ST_ERR])  err_d  = 1'b0;
      if (bus.cfg_data[ST_TMO])  tmo_d  = 1'b0;
    end

    if (prot_wr) begin
      if (state_q != IDLE) begin
        err_d = 1'b1;
      end else begin
        case (off)
          CFG_ADDR_OFF: addr_d = bus.cfg_data[PADDR_W-1:0];
          CFG_OP_OFF:   op_d   = bus.cfg_data[OP_W-1:0];
          CFG_SIZE_OFF: size_d = bus.cfg_data[SIZE_W-1:0];
          default: begin
            if (bus.cfg_data[0]) begin
              if (size_q == '0) begin
                err_d = 1'b1;
              end else begin
                state_d = REQ;
                done_d  = 1'b0;
                err_d   = 1'b0;
                tmo_d   = 1'b0;
              end
            end
          end
        endcase
      end
    end

    if (state_q == REQ && bus.req_ready) state_d = BUSY;

    if (completing) begin
      state_d = IDLE;
      done_d  = 1'b1;
      if (bus.done_err) err_d = 1'b1;
      dcnt_d  = dcnt_q + 32'd1;
    end else if (wd_expire) begin
      state_d = IDLE;
      err_d   = 1'b1;
      tmo_d   = 1'b1;
    end
  end

  // Read mux sees pre-update register values, so a STATUS read in the
  // completion cycle reports the state before completion.
  always_comb begin
    rdata_d = '0;
    case (off)
      CFG_ADDR_OFF:  rdata_d[PADDR_W-1:0] = addr_q;
      CFG_OP_OFF:    rdata_d[OP_W-1:0]    = op_q;
      CFG_SIZE_OFF:  rdata_d[SIZE_W-1:0]  = size_q;
      CFG_START_OFF: rdata_d[3:0]         = status;
      CFG_STAT_OFF:  rdata_d[3:0]         = status;
      CFG_DCNT_OFF:  rdata_d[31:0]        = dcnt_q;
      default:       rdata_d              = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      op_q     <= '0;
      size_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      dcnt_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      op_q     <= op_d;
      size_q   <= size_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      dcnt_q   <= dcnt_d;
      rvalid_q <= rd;
      if (rd) rdata_q <= rdata_d;
    end
  end

  assign bus.cfg_read_data  = rdata_q;
  assign bus.cfg_read_valid = rvalid_q;
  assign bus.req_valid      = (state_q == REQ);
  assign bus.req_addr       = addr_q;
  assign bus.req_op         = op_q;
  assign bus.req_size       = size_q;
endmodule

// File: tb/tb_cohort_config_slave.sv
// Directed, table-driven bench for cohort_config_slave.
module tb_cohort_config_slave;
  import cohort_config_slave_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cohort_config_slave_if bus ();

  cohort_config_slave #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [39:0] addr;
    logic [63:0] data;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [39:0] addr, input logic [63:0] data);
    bus.cfg_valid = 1'b1;
    bus.cfg_type  = CFG_STORE;
    bus.cfg_addr  = addr;
    bus.cfg_data  = data;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic cfg_read(input logic [39:0] addr, output logic [63:0] data);
    bus.cfg_valid = 1'b1;
    bus.cfg_type  = CFG_LOAD;
    bus.cfg_addr  = addr;
    tick();
    bus.cfg_valid = 1'b0;
    check("read_valid_pulse", {63'd0, bus.cfg_read_valid}, 64'd1);
    data = bus.cfg_read_data;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    int n;
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b1, 40'h000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, "w_addr_ones"};
    vecs[1]  = '{1'b0, 40'h000, 64'h0, 64'h00FF_FFFF_FFFF, "r_addr_ones"};
    vecs[2]  = '{1'b1, 40'h004, 64'hFF, 64'h0, "w_op_ff"};
    vecs[3]  = '{1'b0, 40'h004, 64'h0, 64'h3, "r_op_trunc"};
    vecs[4]  = '{1'b1, 40'h008, 64'hF, 64'h0, "w_size_f"};
    vecs[5]  = '{1'b0, 40'h008, 64'h0, 64'h7, "r_size_trunc"};
    vecs[6]  = '{1'b1, 40'h000, 64'h1000, 64'h0, "w_addr"};
    vecs[7]  = '{1'b1, 40'h004, 64'h1, 64'h0, "w_op"};
    vecs[8]  = '{1'b1, 40'h008, 64'h3, 64'h0, "w_size"};
    vecs[9]  = '{1'b0, 40'hAB_CDEF_F000, 64'h0, 64'h1000, "r_addr_upper_ignored"};
    vecs[10] = '{1'b0, 40'h008, 64'h0, 64'h3, "r_size"};
    vecs[11] = '{1'b1, 40'h020, 64'h55, 64'h0, "w_unmapped"};
    vecs[12] = '{1'b0, 40'h020, 64'h0, 64'h0, "r_unmapped"};
    vecs[13] = '{1'b0, 40'h010, 64'h0, 64'h0, "r_status_idle"};
    vecs[14] = '{1'b0, 40'h014, 64'h0, 64'h0, "r_dcnt_zero"};
    vecs[15] = '{1'b0, 40'h004, 64'h0, 64'h1, "r_op"};

    rst_n          = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.cfg_size   = '0;
    bus.cfg_type   = CFG_LOAD;
    bus.req_ready  = 1'b0;
    bus.done_valid = 1'b0;
    bus.done_err   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_req_valid", {63'd0, bus.req_valid}, 64'd0);
    check("rst_read_valid", {63'd0, bus.cfg_read_valid}, 64'd0);
    check("rst_read_data", bus.cfg_read_data, 64'd0);
    check("rst_req_addr", {24'd0, bus.req_addr}, 64'd0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        cfg_write(vecs[i].addr, vecs[i].data);
        check({vecs[i].name, "_noresp"}, {63'd0, bus.cfg_read_valid}, 64'd0);
      end else begin
        cfg_read(vecs[i].addr, rd);
        check(vecs[i].name, rd, vecs[i].exp);
      end
    end

    // zero-wait accept, completion with same-cycle STATUS read
    bus.req_ready = 1'b1;
    cfg_write(40'h00C, 64'h1);
    check("launch_req_valid", {63'd0, bus.req_valid}, 64'd1);
    check("launch_req_addr", {24'd0, bus.req_addr}, 64'h1000);
    check("launch_req_op", {62'd0, bus.req_op}, 64'd1);
    check("launch_req_size", {61'd0, bus.req_size}, 64'd3);
    tick();
    check("accepted_req_valid", {63'd0, bus.req_valid}, 64'd0);
    bus.done_valid = 1'b1;
    cfg_read(40'h010, rd);
    bus.done_valid = 1'b0;
    check("status_in_done_cycle", rd, 64'h1);
    cfg_read(40'h010, rd);
    check("status_after_done", rd, 64'h2);
    cfg_read(40'h014, rd);
    check("dcnt_one", rd, 64'h1);

    // back-pressured request, then busy protection
    bus.req_ready = 1'b0;
    cfg_write(40'h00C, 64'h1);
    for (int k = 0; k < 5; k++) begin
      check("stall_req_valid", {63'd0, bus.req_valid}, 64'd1);
      check("stall_req_addr", {24'd0, bus.req_addr}, 64'h1000);
      check("stall_req_op", {62'd0, bus.req_op}, 64'd1);
      check("stall_req_size", {61'd0, bus.req_size}, 64'd3);
      tick();
    end
    bus.req_ready = 1'b1;
    check("stall_cycle6_valid", {63'd0, bus.req_valid}, 64'd1);
    tick();
    bus.req_ready = 1'b0;
    check("stall_accepted", {63'd0, bus.req_valid}, 64'd0);
    cfg_write(40'h000, 64'h2000);
    check("busy_addr_kept", {24'd0, bus.req_addr}, 64'h1000);
    cfg_read(40'h00C, rd);
    check("busy_start_read", rd, 64'h5);
    tick();
    check("read_valid_drops", {63'd0, bus.cfg_read_valid}, 64'd0);
    check("read_data_holds", bus.cfg_read_data, 64'h5);

    // W1C of err in the same cycle as a done_err set: set wins
    bus.done_valid = 1'b1;
    bus.done_err   = 1'b1;
    cfg_write(40'h010, 64'h4);
    bus.done_valid = 1'b0;
    bus.done_err   = 1'b0;
    cfg_read(40'h010, rd);
    check("set_wins_w1c", rd, 64'h6);
    cfg_read(40'h014, rd);
    check("dcnt_two", rd, 64'h2);
    cfg_write(40'h010, 64'hE);
    cfg_read(40'h010, rd);
    check("w1c_all", rd, 64'h0);
    bus.done_valid = 1'b1;
    tick();
    bus.done_valid = 1'b0;
    cfg_read(40'h014, rd);
    check("done_idle_ignored", rd, 64'h2);

    // START with SIZE==0 and START with data[0]=0
    cfg_write(40'h008, 64'h0);
    cfg_write(40'h00C, 64'h1);
    check("size0_no_req", {63'd0, bus.req_valid}, 64'd0);
    cfg_read(40'h010, rd);
    check("size0_err", rd, 64'h4);
    cfg_write(40'h010, 64'h4);
    cfg_read(40'h010, rd);
    check("size0_cleared", rd, 64'h0);
    cfg_write(40'h008, 64'h3);
    cfg_write(40'h00C, 64'h2);
    check("start0_no_req", {63'd0, bus.req_valid}, 64'd0);
    cfg_read(40'h010, rd);
    check("start0_status", rd, 64'h0);

    // reset while in REQ
    cfg_write(40'h00C, 64'h1);
    check("pre_reset_req", {63'd0, bus.req_valid}, 64'd1);
    cfg_read(40'h000, rd);
    check("pre_reset_addr", rd, 64'h1000);
    rst_n = 1'b0;
    #1;
    check("reset_req_valid", {63'd0, bus.req_valid}, 64'd0);
    check("reset_read_data", bus.cfg_read_data, 64'd0);
    check("reset_read_valid", {63'd0, bus.cfg_read_valid}, 64'd0);
    check("reset_req_addr", {24'd0, bus.req_addr}, 64'd0);
    check("reset_req_size", {61'd0, bus.req_size}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_reset_no_rvalid", {63'd0, bus.cfg_read_valid}, 64'd0);
    cfg_read(40'h010, rd);
    check("post_reset_status", rd, 64'h0);
    cfg_read(40'h014, rd);
    check("post_reset_dcnt", rd, 64'h0);

    // watchdog, or indefinite wait when it is compiled out
    cfg_write(40'h008, 64'h1);
    cfg_write(40'h00C, 64'h1);
    n = 0;
    while (bus.req_valid && n < 40) begin
      n++;
      tick();
    end
`ifdef COHORT_CFG_TIMEOUT_EN
    check("timeout_cycles", 64'(n), 64'd16);
    cfg_read(40'h010, rd);
    check("timeout_status", rd, 64'hC);
    cfg_read(40'h014, rd);
    check("timeout_dcnt", rd, 64'h0);
`else
    check("no_timeout_waits", 64'(n), 64'd40);
    cfg_read(40'h010, rd);
    check("no_timeout_status", rd, 64'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
